pc_sequencer: RTL and testbench

- Program-counter and run-control sequencer for the 9-bit-instruction CPU core.
- Sits between instruction memory and the instruction decoder. It consumes the decoder's branch, halt and noop strobes plus the ALU compare flags.
- Each cycle it produces the next fetch address, and it manages the start/done handshake with the testbench or host.
- Absolute branch targets come from a 16-entry branch-target LUT. Relative branches use a signed 4-bit offset.

---
 rtl/pc_sequencer_pkg.sv | 28 ++
 rtl/pc_sequencer_if.sv | 44 ++++
 rtl/pc_sequencer_branch_target_lut.sv | 14 +
 rtl/pc_sequencer.sv | 116 +++++++++++
 tb/tb_pc_sequencer.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - condition encodings, sequencer states and branch-target table
package pc_sequencer_pkg;

  localparam logic [1:0] COND_NONE = 2'd0;
  localparam logic [1:0] COND_LT   = 2'd1;
  localparam logic [1:0] COND_GT   = 2'd2;
  localparam logic [1:0] COND_EQ   = 2'd3;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_HALTED} seq_state_t;

  localparam int LUT_W = 10;

  localparam logic [LUT_W-1:0] BRANCH_LUT [16] = '{
    10'd16,  10'd32,  10'd100, 10'd200, 10'd300, 10'd400,  10'd500,  10'd600,
    10'd700, 10'd800, 10'd900, 10'd1020, 10'd1023, 10'd50, 10'd7,   10'd512
  };

  function automatic logic cond_true(input logic [1:0] sel, input logic lt,
                                     input logic gt, input logic eq);
    case (sel)
      COND_LT: return lt;
      COND_GT: return gt;
      COND_EQ: return eq;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - decoder/host-facing bundle of pc_sequencer
// Optional PC_SEQ_PERF_CNT_EN adds the cycle and retired counters.
interface pc_sequencer_if #(parameter int PC_W = 10);
  logic            start;
  logic            stall;
  logic            halt_en;
  logic            noop_en;
  logic            abs_branch_en;
  logic            rel_branch_en;
  logic [1:0]      cond_sel;
  logic [3:0]      rel_branch_offset;
  logic [3:0]      abs_branch_LUT_index;
  logic            flag_lt;
  logic            flag_gt;
  logic            flag_eq;
  logic [PC_W-1:0] pc_out;
  logic            running;
  logic            done;
  logic            branch_taken;
`ifdef PC_SEQ_PERF_CNT_EN
  logic [15:0]     cycle_cnt;
  logic [15:0]     retired_cnt;
`endif

  modport master (
    output start, stall, halt_en, noop_en, abs_branch_en, rel_branch_en,
           cond_sel, rel_branch_offset, abs_branch_LUT_index,
           flag_lt, flag_gt, flag_eq,
    input  pc_out, running, done, branch_taken
`ifdef PC_SEQ_PERF_CNT_EN
    , input cycle_cnt, retired_cnt
`endif
  );

  modport slave (
    input  start, stall, halt_en, noop_en, abs_branch_en, rel_branch_en,
           cond_sel, rel_branch_offset, abs_branch_LUT_index,
           flag_lt, flag_gt, flag_eq,
    output pc_out, running, done, branch_taken
`ifdef PC_SEQ_PERF_CNT_EN
    , output cycle_cnt, retired_cnt
`endif
  );
endinterface

// File: rtl/pc_sequencer_branch_target_lut.sv
// rtl/pc_sequencer_branch_target_lut.sv - combinational absolute branch-target lookup
module branch_target_lut
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic [3:0]      idx_i,
  output logic [PC_W-1:0] target_o
);

  // Table entries are zero-extended or truncated to the PC width.
  assign target_o = PC_W'(BRANCH_LUT[idx_i]);

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and run control (IDLE/RUN/HALTED)
// Optional PC_SEQ_PERF_CNT_EN adds saturating cycle/retired counters.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W     = 10,
  parameter int START_PC = 0
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  localparam logic [PC_W-1:0] START_VAL = PC_W'(START_PC);

  seq_state_t      state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            running_q;
  logic            done_q;
  logic            taken_q;
  logic            taken_d;
  logic            cond_ok;
  logic [PC_W-1:0] lut_target;
  logic [PC_W-1:0] rel_ext;
  logic            noop_unused;

  // NOOP needs no special handling: it advances like any non-branch.
  assign noop_unused = bus.noop_en;

  branch_target_lut #(.PC_W(PC_W)) u_lut (
    .idx_i    (bus.abs_branch_LUT_index),
    .target_o (lut_target)
  );

  always_comb begin
    cond_ok = cond_true(bus.cond_sel, bus.flag_lt, bus.flag_gt, bus.flag_eq);
    rel_ext = {{(PC_W-4){bus.rel_branch_offset[3]}}, bus.rel_branch_offset};
    pc_d    = pc_q + PC_W'(1);
    taken_d = 1'b0;
    if (bus.abs_branch_en && cond_ok) begin
      pc_d    = lut_target;
      taken_d = 1'b1;
    end else if (bus.rel_branch_en && cond_ok) begin
      pc_d    = pc_q + rel_ext;
      taken_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SEQ_IDLE;
      pc_q      <= START_VAL;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      taken_q   <= 1'b0;
    end else begin
      taken_q <= 1'b0;
      case (state_q)
        SEQ_IDLE, SEQ_HALTED: begin
          if (bus.start) begin
            state_q   <= SEQ_RUN;
            pc_q      <= START_VAL;
            running_q <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        SEQ_RUN: begin
          if (!bus.stall) begin
            if (bus.halt_en) begin
              // PC stays on the HALT instruction.
              state_q   <= SEQ_HALTED;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              pc_q    <= pc_d;
              taken_q <= taken_d;
            end
          end
        end
        default: begin
          state_q   <= SEQ_IDLE;
          running_q <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_out       = pc_q;
  assign bus.running      = running_q;
  assign bus.done         = done_q;
  assign bus.branch_taken = taken_q;

`ifdef PC_SEQ_PERF_CNT_EN
  logic [15:0] cycle_cnt_q;
  logic [15:0] retired_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else if (state_q != SEQ_RUN && bus.start) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else if (state_q == SEQ_RUN) begin
      if (cycle_cnt_q != 16'hFFFF) cycle_cnt_q <= cycle_cnt_q + 16'd1;
      if (!bus.stall && retired_cnt_q != 16'hFFFF) retired_cnt_q <= retired_cnt_q + 16'd1;
    end
  end

  assign bus.cycle_cnt   = cycle_cnt_q;
  assign bus.retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized checks of pc_sequencer against a reference model
module tb_pc_sequencer;
  localparam int PC_W   = 10;
  localparam int PC_MOD = 1 << PC_W;

  logic clk = 1'b0;
  logic reset;

  pc_sequencer_if #(.PC_W(PC_W)) bus();

  pc_sequencer #(.PC_W(PC_W), .START_PC(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int lut [16] = '{16, 32, 100, 200, 300, 400, 500, 600,
                   700, 800, 900, 1020, 1023, 50, 7, 512};

  // Model state: 0 = idle, 1 = running, 2 = halted
  int m_st, m_pc, m_taken, m_cyc, m_ret;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic check_outputs();
    check_val("pc_out", int'(bus.pc_out), m_pc);
    check_val("running", int'(bus.running), int'(m_st == 1));
    check_val("done", int'(bus.done), int'(m_st == 2));
    check_val("branch_taken", int'(bus.branch_taken), m_taken);
`ifdef PC_SEQ_PERF_CNT_EN
    check_val("cycle_cnt", int'(bus.cycle_cnt), m_cyc);
    check_val("retired_cnt", int'(bus.retired_cnt), m_ret);
`endif
  endtask

  task automatic model_reset();
    m_st = 0; m_pc = 0; m_taken = 0; m_cyc = 0; m_ret = 0;
  endtask

  task automatic clr();
    bus.start = 0; bus.stall = 0; bus.halt_en = 0; bus.noop_en = 0;
    bus.abs_branch_en = 0; bus.rel_branch_en = 0; bus.cond_sel = 2'd0;
    bus.rel_branch_offset = 4'd0; bus.abs_branch_LUT_index = 4'd0;
    bus.flag_lt = 0; bus.flag_gt = 0; bus.flag_eq = 0;
  endtask

  task automatic tick();
    int  npc = m_pc;
    int  nst = m_st;
    int  ntk = 0;
    int  off;
    bit  ct;
    if (m_st != 1) begin
      if (bus.start) begin
        nst = 1; npc = 0; m_cyc = 0; m_ret = 0;
      end
    end else begin
      if (m_cyc < 65535) m_cyc++;
      if (!bus.stall) begin
        if (m_ret < 65535) m_ret++;
        case (int'(bus.cond_sel))
          1: ct = bus.flag_lt;
          2: ct = bus.flag_gt;
          3: ct = bus.flag_eq;
          default: ct = 1'b1;
        endcase
        off = int'(bus.rel_branch_offset);
        if (off >= 8) off -= 16;
        if (bus.halt_en) nst = 2;
        else if (bus.abs_branch_en && ct) begin
          npc = lut[int'(bus.abs_branch_LUT_index)] % PC_MOD; ntk = 1;
        end else if (bus.rel_branch_en && ct) begin
          npc = (m_pc + off + PC_MOD) % PC_MOD; ntk = 1;
        end else npc = (m_pc + 1) % PC_MOD;
      end
    end
    @(posedge clk);
    #1;
    m_pc = npc; m_st = nst; m_taken = ntk;
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    clr();
    reset = 1'b0;
    #2 reset = 1'b1;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    reset = 1'b0;

    bus.start = 1; tick();
    clr(); ticks(5);
    check_val("seq_pc5", int'(bus.pc_out), 5);
    ticks(2);

    bus.rel_branch_en = 1; bus.cond_sel = 2'd3; bus.flag_eq = 1; bus.rel_branch_offset = 4'b1101;
    tick();
    check_val("rel_taken_pc", int'(bus.pc_out), 4);
    check_val("rel_taken_flag", int'(bus.branch_taken), 1);
    clr(); ticks(3);
    bus.rel_branch_en = 1; bus.cond_sel = 2'd3; bus.flag_eq = 0; bus.rel_branch_offset = 4'b1101;
    tick();
    check_val("rel_untaken_pc", int'(bus.pc_out), 8);
    check_val("rel_untaken_flag", int'(bus.branch_taken), 0);

    clr(); bus.halt_en = 1; tick();
    clr(); bus.start = 1; tick();
    clr(); ticks(3);
    bus.abs_branch_en = 1; bus.rel_branch_en = 1; bus.abs_branch_LUT_index = 4'd2;
    bus.rel_branch_offset = 4'd5;
    tick();
    check_val("abs_wins_pc", int'(bus.pc_out), 100);

    clr(); bus.halt_en = 1; tick();
    clr(); bus.start = 1; tick();
    clr(); ticks(9);
    bus.stall = 1; bus.halt_en = 1; ticks(3);
    check_val("stall_pc", int'(bus.pc_out), 9);
    check_val("stall_running", int'(bus.running), 1);
    bus.stall = 0; tick();
    check_val("halt_done", int'(bus.done), 1);
    check_val("halt_pc", int'(bus.pc_out), 9);
    clr(); bus.start = 1; tick();
    check_val("restart_pc", int'(bus.pc_out), 0);
    check_val("restart_done", int'(bus.done), 0);

    clr(); bus.abs_branch_en = 1; bus.abs_branch_LUT_index = 4'd12; tick();
    clr(); tick();
    check_val("wrap_pc", int'(bus.pc_out), 0);
    bus.abs_branch_en = 1; bus.abs_branch_LUT_index = 4'd11; tick();
    clr(); bus.rel_branch_en = 1; bus.rel_branch_offset = 4'd7; tick();
    check_val("rel_wrap_pc", int'(bus.pc_out), 3);

    clr(); bus.abs_branch_en = 1; bus.abs_branch_LUT_index = 4'd13; tick();
    clr();
    #2 reset = 1'b1;
    #1 model_reset();
    check_val("async_rst_pc", int'(bus.pc_out), 0);
    check_val("async_rst_running", int'(bus.running), 0);
    check_outputs();
    @(negedge clk);
    reset = 1'b0;

    bus.start = 1; tick();
    clr();
    for (int i = 0; i < 10; i++) begin
      bus.stall = (i == 3 || i == 6);
      tick();
    end
`ifdef PC_SEQ_PERF_CNT_EN
    check_val("perf_cycles", int'(bus.cycle_cnt), 10);
    check_val("perf_retired", int'(bus.retired_cnt), 8);
`endif

    for (int i = 0; i < 800; i++) begin
      bus.start                = ($urandom_range(0, 9) == 0);
      bus.stall                = ($urandom_range(0, 3) == 0);
      bus.halt_en              = ($urandom_range(0, 15) == 0);
      bus.noop_en              = 1'($urandom);
      bus.abs_branch_en        = ($urandom_range(0, 4) == 0);
      bus.rel_branch_en        = ($urandom_range(0, 2) == 0);
      bus.cond_sel             = 2'($urandom);
      bus.rel_branch_offset    = 4'($urandom);
      bus.abs_branch_LUT_index = 4'($urandom);
      bus.flag_lt              = 1'($urandom);
      bus.flag_gt              = 1'($urandom);
      bus.flag_eq              = 1'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
